cpu_mem_arbiter: RTL and testbench

//   Shares the single-port 256x8 data RAM between two requesters: the CPU load/store unit (port A)
//   and the vector/DMA engine (port B). Arbitrates, latches the winner's request, drives the RAM

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/cpu_mem_arbiter_if.sv | 43 ++++
 rtl/cpu_rr_arb2.sv | 33 +++
 rtl/cpu_mem_arbiter.sv | 100 ++++++++++
 tb/tb_cpu_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU/DMA data-RAM arbiter.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the data RAM.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_enable;
    logic [ADDR_W-1:0] mem_adress;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] dout_ram;
    logic              busy;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  dout_ram,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output mem_enable, mem_adress, mem_din, busy
    );

    // Requesters plus RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output dout_ram,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  mem_enable, mem_adress, mem_din, busy
    );
endinterface

// File: rtl/cpu_rr_arb2.sv
// Two-way request picker. Round-robin on ties by default; defining
// CPU_MEM_ARB_CPU_PRIO_EN gives the CPU fixed priority instead.
module cpu_rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     winner,
    output logic       valid
);

`ifdef CPU_MEM_ARB_CPU_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        valid  = |req;
        winner = OWN_CPU;
        if (!req[0] && req[1]) winner = OWN_DMA;
    end
`else
    always_comb begin
        valid  = |req;
        winner = OWN_CPU;
        if (req == 2'b10) begin
            winner = OWN_DMA;
        end else if (req == 2'b11 && last_owner == OWN_CPU) begin
            winner = OWN_DMA;
        end
    end
`endif

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares the single-port data RAM between CPU (bit 0) and DMA (bit 1).
// Tie policy selected by CPU_MEM_ARB_CPU_PRIO_EN inside cpu_rr_arb2.
//
// state  | meaning
// IDLE   | waiting; arbitrate and latch the winner's request
// ACCESS | drive RAM with latched request, capture read data
// RESP   | one-cycle ack to the owner
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    cpu_mem_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    owner_t            winner;
    logic              grant_valid;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    cpu_rr_arb2 u_arb (
        .req        ({bus.dma_req, bus.cpu_req}),
        .last_owner (last_owner_q),
        .winner     (winner),
        .valid      (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DMA;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d      = winner;
                    last_owner_d = winner;
                    if (winner == OWN_CPU) begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                    end else begin
                        we_d    = bus.dma_we;
                        addr_d  = bus.dma_addr;
                        wdata_d = bus.dma_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // For a write this is the pre-write value, returned as rdata.
                rdata_d = bus.dout_ram;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_enable = (state_q == ACCESS) && we_q;
    assign bus.mem_adress = addr_q;
    assign bus.mem_din    = wdata_q;
    assign bus.cpu_ack    = (state_q == RESP) && (owner_q == OWN_CPU);
    assign bus.dma_ack    = (state_q == RESP) && (owner_q == OWN_DMA);
    assign bus.cpu_rdata  = rdata_q;
    assign bus.dma_rdata  = rdata_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter with a behavioural RAM and transaction-level model.
module tb_cpu_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_load = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   en_cnt = 0;
    logic en_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    cpu_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h0A:   return 8'd2;
            8'h0B:   return 8'd3;
            8'h81:   return 8'd2;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    // Behavioural cpu_ram: async read, write on the clock edge
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
        end else if (bus.mem_enable === 1'b1) begin
            ram[bus.mem_adress] <= bus.mem_din;
        end
    end
    assign bus.dout_ram = ram[bus.mem_adress];

    // Reference model: memory contents as seen in request-issue order
    logic [7:0] model [256];

    typedef struct {
        logic [7:0] data;
        int         issue;
        int         lat;
    } exp_t;

    exp_t q_cpu[$];
    exp_t q_dma[$];
    int   ack_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_port(input int p, input logic [7:0] rdata);
        exp_t e;
        int   lat;
        string nm;
        nm = (p == 0) ? "cpu" : "dma";
        ack_log.push_back(p);
        if ((p == 0 && q_cpu.size() == 0) || (p == 1 && q_dma.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_ack: got ack expected none (cycle %0d)", nm, cyc);
        end else begin
            e   = (p == 0) ? q_cpu.pop_front() : q_dma.pop_front();
            lat = cyc - e.issue;
            chk({nm, "_rdata"}, 32'(rdata), 32'(e.data));
            if (e.lat > 0) chk({nm, "_latency"}, lat, e.lat);
            else           chk({nm, "_latency_bound"}, 32'(lat >= 2 && lat <= 5), 1);
        end
    endtask

    always @(negedge clk) begin
        if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1)
            chk("ack_exclusive", 32'({bus.cpu_ack, bus.dma_ack} != 2'b11), 1);
        if (bus.cpu_ack === 1'b1) mon_port(0, bus.cpu_rdata);
        if (bus.dma_ack === 1'b1) mon_port(1, bus.dma_rdata);
        if (bus.mem_enable === 1'b1) begin
            en_cnt++;
            chk("mem_enable_width", 32'(en_prev), 0);
        end
        en_prev = (bus.mem_enable === 1'b1);
    end

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wd);
        if (p == 0) begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        end else begin
            bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wd;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with req low
    task automatic txn(input int p, input logic we, input logic [7:0] addr,
                       input logic [7:0] wd, input int lat, input bit scramble);
        exp_t e;
        bit   got;
        got     = 1'b0;
        e.data  = model[addr];
        e.issue = cyc;
        e.lat   = lat;
        if (we) model[addr] = wd;
        if (p == 0) q_cpu.push_back(e);
        else        q_dma.push_back(e);
        drive(p, 1'b1, we, addr, wd);
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (scramble && c == 0) drive(p, 1'b1, we, addr + 8'd1, ~wd);
            @(negedge clk);
            got = (p == 0) ? (bus.cpu_ack === 1'b1) : (bus.dma_ack === 1'b1);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: got no ack expected ack within 20 cycles",
                     (p == 0) ? "cpu" : "dma");
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int en0;
        for (int i = 0; i < 256; i++) model[i] = init_val(8'(i));
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; ram_load = 1'b0;

        @(negedge clk);
        chk("rst_busy",       32'(bus.busy), 0);
        chk("rst_cpu_ack",    32'(bus.cpu_ack), 0);
        chk("rst_dma_ack",    32'(bus.dma_ack), 0);
        chk("rst_mem_enable", 32'(bus.mem_enable), 0);
        chk("rst_mem_adress", 32'(bus.mem_adress), 0);
        chk("rst_mem_din",    32'(bus.mem_din), 0);
        chk("rst_rdata",      32'(bus.cpu_rdata), 0);
        @(posedge clk); #1;

        // First tie after reset: CPU then DMA
        base = ack_log.size();
        fork
            txn(0, 1'b0, 8'h0B, 8'h00, 2, 1'b0);
            txn(1, 1'b0, 8'h81, 8'h00, 5, 1'b0);
        join
        chk("tie_order_0", 32'(ack_log[base]), 0);
        chk("tie_order_1", 32'(ack_log[base+1]), 1);
        idle(2);

        // Continuous contention: alternation CPU, DMA, CPU, DMA
        base = ack_log.size();
        fork
            begin
                txn(0, 1'b0, 8'h10, 8'h00, 2, 1'b0);
                txn(0, 1'b1, 8'h11, 8'h3C, 5, 1'b0);
            end
            begin
                txn(1, 1'b1, 8'h90, 8'hC3, 5, 1'b0);
                txn(1, 1'b0, 8'h90, 8'h00, 5, 1'b0);
            end
        join
        for (int i = 0; i < 4; i++) chk("rr_alternate", 32'(ack_log[base+i]), 32'(i % 2));
        idle(2);

        // Lone CPU read
        base = ack_log.size();
        txn(0, 1'b0, 8'h0A, 8'h00, 2, 1'b0);
        chk("lone_cpu_ack_count", 32'(ack_log.size() - base), 1);
        idle(1);

        // DMA write then read, single-cycle write enable
        en0 = en_cnt;
        txn(1, 1'b1, 8'h80, 8'h55, 2, 1'b0);
        chk("dma_write_en_cycles", 32'(en_cnt - en0), 1);
        txn(1, 1'b0, 8'h80, 8'h00, 2, 1'b0);
        idle(1);

        // Payload changed after grant must be ignored
        txn(0, 1'b1, 8'h20, 8'h77, 2, 1'b1);
        txn(0, 1'b0, 8'h20, 8'h00, 2, 1'b0);
        txn(0, 1'b0, 8'h21, 8'h00, 2, 1'b0);
        idle(1);

        // Reset during ACCESS of a CPU write: write lands, no ack
        drive(0, 1'b1, 1'b1, 8'h0C, 8'hAA);
        model[8'h0C] = 8'hAA;
        @(posedge clk); #1;
        @(negedge clk);
        chk("access_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("rst_access_busy", 32'(bus.busy), 0);
        chk("rst_access_no_ack", 32'(bus.cpu_ack), 0);
        idle(4);
        chk("rst_access_ram", 32'(ram[8'h0C]), 32'h000000AA);

        // Randomized traffic, disjoint halves of the address space per port
        fork
            for (int n = 0; n < 40; n++) begin
                idle($urandom_range(0, 3));
                txn(0, 1'($urandom), 8'($urandom_range(0, 127)), 8'($urandom), 0, 1'b0);
            end
            for (int n = 0; n < 40; n++) begin
                idle($urandom_range(0, 3));
                txn(1, 1'($urandom), 8'($urandom_range(128, 255)), 8'($urandom), 0, 1'b0);
            end
        join
        idle(5);
        chk("cpu_queue_drained", 32'(q_cpu.size()), 0);
        chk("dma_queue_drained", 32'(q_dma.size()), 0);
        chk("ram_0c_final", 32'(ram[8'h0C]), 32'(model[8'h0C]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
